// File: rtl/sv_sq.sv
// Microprogram sequencer: fetches 16-bit words, issues execution words to the unit, runs control words locally.
// Optional WAIT watchdog enabled by defining SV_SQ_WDOG_EN (abort after WDOG_LIMIT cycles without ready).
module sv_sq #(
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 12,
    parameter int WDOG_LIMIT = 65535
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] entry_i,
    output logic [ADDR_W-1:0] pm_addr_o,
    output logic              pm_rd_o,
    input  logic [15:0]       pm_data_i,
    output logic              ex_v_o,
    output logic [14:0]       ex_i_o,
    input  logic              ex_ready_i,
    input  logic              ex_comp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] pc_o
);

    if (ADDR_W < 1 || ADDR_W > 12) begin : g_bad_addr_w
        $error("sv_sq: ADDR_W must be in 1..12");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog
        $error("sv_sq: WDOG_LIMIT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [14:0]       ex_i_q, ex_i_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wait_first_q, wait_first_d;

    logic [2:0]        kind;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;

    assign kind   = pm_data_i[14:12];
    assign target = pm_data_i[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef SV_SQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expire;

    // Counter is zero outside WAIT, so it starts fresh on every WAIT entry.
    assign wd_expire = (state_q == S_WAIT) && (wd_q == WD_W'(WDOG_LIMIT - 1));

    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT) wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        ex_i_d       = ex_i_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        wait_first_d = 1'b0;
        ex_v_o       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d    = entry_i;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (!pm_data_i[15]) begin
                    ex_i_d  = pm_data_i[14:0];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (kind)
                        3'b000: begin
                            pc_d    = pc_q;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        3'b001: pc_d = target;
                        3'b010: if (ex_comp_i)  pc_d = target;
                        3'b011: if (!ex_comp_i) pc_d = target;
                        3'b100: cnt_d = CNT_W'(pm_data_i[11:0]);
                        3'b101: begin
                            // Exhausted counter falls through and stays at zero.
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_W'(1);
                                if (cnt_q != CNT_W'(1)) pc_d = target;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
                if (ex_ready_i) begin
                    ex_v_o       = 1'b1;
                    pc_d         = pc_inc;
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // Ready in the cycle right after the pulse is stale and ignored.
                if (!wait_first_q && ex_ready_i) begin
                    state_d = S_FETCH;
                end
`ifdef SV_SQ_WDOG_EN
                else if (wd_expire) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            ex_i_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            ex_i_q       <= ex_i_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign pm_addr_o = pc_q;
    assign pm_rd_o   = (state_q == S_FETCH);
    assign ex_i_o    = ex_i_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign pc_o      = pc_q;

endmodule

// File: tb/tb_sv_sq.sv
// Bench for sv_sq: ISA-level program interpreter predicts fetch/issue order, a negedge monitor checks the DUT.
module tb_sv_sq;

    logic        clk;
    logic        areset;
    logic        start_i;
    logic [9:0]  entry_i;
    logic [9:0]  pm_addr_o;
    logic        pm_rd_o;
    logic [15:0] pm_data_i;
    logic        ex_v_o;
    logic [14:0] ex_i_o;
    logic        ex_ready_i;
    logic        ex_comp_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [9:0]  pc_o;

    sv_sq #(.ADDR_W(10), .CNT_W(12), .WDOG_LIMIT(8)) dut (
        .clk(clk), .areset(areset), .start_i(start_i), .entry_i(entry_i),
        .pm_addr_o(pm_addr_o), .pm_rd_o(pm_rd_o), .pm_data_i(pm_data_i),
        .ex_v_o(ex_v_o), .ex_i_o(ex_i_o), .ex_ready_i(ex_ready_i), .ex_comp_i(ex_comp_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pc_o(pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [1024];
    int   exp_fetch[$];
    int   exp_issue[$];
    int   m_pc, m_cnt;
    bit   m_err;

    // execution-unit / memory model state
    int   eu_lat = 0, eu_cnt = 0, stall = 0;
    bit   eu_comp = 0;
    bit   rd_pend = 0, v_seen = 0;
    int   rd_addr = 0;

    // monitor state
    int   cyc = 0, n_pulse = 0, n_done = 0, pulse_cyc = 0, last_fetch = -1, done_cyc = 0;
    bit   hold = 0;
    int   last_iss = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Instruction-level interpreter of the program in mem.
    task automatic model_run(input int entry, input bit comp);
        int pc;
        logic [15:0] w;
        bit fin;
        exp_fetch.delete();
        exp_issue.delete();
        pc = entry; fin = 0; m_err = 0;
        for (int s = 0; s < 500 && !fin; s++) begin
            exp_fetch.push_back(pc);
            w = mem[pc];
            if (!w[15]) begin
                exp_issue.push_back(int'(w[14:0]));
                pc = (pc + 1) % 1024;
            end else begin
                case (w[14:12])
                    3'd0: fin = 1;
                    3'd1: pc = int'(w[9:0]);
                    3'd2: pc = comp ? int'(w[9:0]) : (pc + 1) % 1024;
                    3'd3: pc = !comp ? int'(w[9:0]) : (pc + 1) % 1024;
                    3'd4: begin m_cnt = int'(w[11:0]); pc = (pc + 1) % 1024; end
                    3'd5: begin
                        if (m_cnt != 0) begin
                            m_cnt--;
                            pc = (m_cnt != 0) ? int'(w[9:0]) : (pc + 1) % 1024;
                        end else pc = (pc + 1) % 1024;
                    end
                    default: begin m_err = 1; pc = (pc + 1) % 1024; end
                endcase
            end
        end
        m_pc = pc;
    endtask

    // Memory and execution-unit responder; inputs change 1 time unit after the edge.
    initial begin
        ex_ready_i = 1'b1;
        ex_comp_i  = 1'b0;
        pm_data_i  = 16'h0;
        forever begin
            @(posedge clk); #1;
            pm_data_i = rd_pend ? mem[rd_addr] : 16'h7E5A;
            if (v_seen) eu_cnt = eu_lat;
            else if (eu_cnt > 0) eu_cnt--;
            if (stall > 0) stall--;
            ex_ready_i = (eu_cnt == 0) && (stall == 0);
            ex_comp_i  = eu_comp;
        end
    end

    // Monitor: compares every fetch, every issue and the held instruction against the model.
    initial begin
        int e, gap;
        forever begin
            @(negedge clk);
            cyc++;
            rd_pend = pm_rd_o;
            rd_addr = int'(pm_addr_o);
            v_seen  = ex_v_o;
            if (!areset) begin
                hold = 0;
                continue;
            end
            if (done_o) begin n_done++; done_cyc = cyc; end
            if (pm_rd_o) begin
                e = (exp_fetch.size() > 0) ? exp_fetch.pop_front() : -1;
                chk("fetch_addr", pm_addr_o, e);
                if (hold) begin
                    gap = ((eu_lat + 1 > 2) ? eu_lat + 1 : 2) + 1;
                    chk("wait_len", cyc - pulse_cyc, gap);
                end else if (last_fetch >= 0) begin
                    chk("ctl_len", cyc - last_fetch, 2);
                end
                hold = 0;
                last_fetch = cyc;
            end
            if (ex_v_o) begin
                chk("v_needs_ready", ex_ready_i, 1);
                chk("v_during_wait", hold, 0);
                e = (exp_issue.size() > 0) ? exp_issue.pop_front() : -1;
                chk("issue_word", ex_i_o, e);
                n_pulse++;
                hold = 1;
                pulse_cyc = cyc;
                last_iss = int'(ex_i_o);
            end else if (hold) begin
                chk("ex_i_stable", ex_i_o, last_iss);
            end
        end
    end

    task automatic start_prog(input int entry);
        @(posedge clk); #1;
        entry_i = 10'(entry);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run(input string nm, input int entry, input int lat, input bit comp, input int stl,
                       input int x_pulses, input int x_fetches, input int x_pc, input bit x_err);
        model_run(entry, comp);
        chk({nm, "_model_pulses"},  exp_issue.size(), x_pulses);
        chk({nm, "_model_fetches"}, exp_fetch.size(), x_fetches);
        chk({nm, "_model_pc"},      m_pc, x_pc);
        chk({nm, "_model_err"},     m_err, x_err);
        eu_lat = lat; eu_comp = comp; stall = stl;
        n_pulse = 0; n_done = 0; last_fetch = -1;
        start_prog(entry);
        for (int i = 0; i < 3000 && n_done == 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk({nm, "_done_pulses"}, n_done, 1);
        chk({nm, "_busy"},        busy_o, 0);
        chk({nm, "_pc"},          pc_o, m_pc);
        chk({nm, "_err"},         err_o, m_err);
        chk({nm, "_pulses"},      n_pulse, exp_issue.size() + n_pulse - n_pulse + x_pulses - exp_issue.size());
        chk({nm, "_fetch_left"},  exp_fetch.size(), 0);
        chk({nm, "_issue_left"},  exp_issue.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h8000;
        start_i = 1'b0;
        entry_i = '0;
        areset  = 1'b1;
        m_cnt   = 0;
        #2 areset = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_pc",   pc_o, 0);
        chk("rst_rd",   pm_rd_o, 0);
        chk("rst_v",    ex_v_o, 0);
        chk("rst_err",  err_o, 0);
        chk("rst_done", done_o, 0);
        repeat (3) @(posedge clk);
        #3 areset = 1'b1;

        // single exec word then HALT
        mem[0] = 16'h0123; mem[1] = 16'h8000;
        run("basic", 0, 3, 0, 0, 1, 2, 1, 0);

        // LDC 3 / exec / DJNZ loop / HALT
        mem[5] = 16'hC003; mem[6] = 16'h0801; mem[7] = 16'hD006; mem[8] = 16'h8000;
        run("djnz", 5, 0, 0, 0, 3, 8, 8, 0);

        // compare word then BRC, fall through to BRNC
        mem[16'h20] = 16'h6000; mem[16'h21] = 16'hA010; mem[16'h22] = 16'hB040;
        mem[16'h10] = 16'h8000; mem[16'h40] = 16'h8000;
        run("brc_taken", 32'h20, 1, 1, 0, 1, 3, 32'h10, 0);
        run("brnc_taken", 32'h20, 1, 0, 0, 1, 4, 32'h40, 0);

        // unit busy before issue, plus a start_i pulse that must be ignored
        mem[16'h50] = 16'h1234; mem[16'h51] = 16'h8000; mem[16'h60] = 16'h8000;
        fork
            run("stall", 32'h50, 2, 0, 10, 1, 2, 32'h51, 0);
            begin
                repeat (6) @(posedge clk);
                #1 entry_i = 10'h060; start_i = 1'b1;
                @(posedge clk); #1 start_i = 1'b0;
            end
        join

        // pc wrap and reserved word
        mem[1023] = 16'h0555; mem[0] = 16'hE000; mem[1] = 16'h8000;
        run("wrap_rsvd", 1023, 0, 0, 0, 1, 3, 1, 1);

        // DJNZ with exhausted counter falls through, then JMP
        mem[16'h100] = 16'hD123; mem[16'h101] = 16'h9200; mem[16'h200] = 16'h8000;
        run("djnz0_jmp", 32'h100, 0, 0, 0, 0, 3, 32'h200, 0);

        // reset during WAIT
        mem[16'h300] = 16'hF000; mem[16'h301] = 16'h0AAA; mem[16'h302] = 16'h8000;
        model_run(32'h300, 0);
        eu_lat = 30; n_pulse = 0; last_fetch = -1;
        start_prog(32'h300);
        for (int i = 0; i < 100 && n_pulse == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_err", err_o, 1);
        chk("pre_rst_busy", busy_o, 1);
        areset = 1'b0;
        #1;
        chk("mid_rst_addr", pm_addr_o, 0);
        chk("mid_rst_rd",   pm_rd_o, 0);
        chk("mid_rst_v",    ex_v_o, 0);
        chk("mid_rst_i",    ex_i_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_err",  err_o, 0);
        chk("mid_rst_pc",   pc_o, 0);
        @(posedge clk); #3;
        areset = 1'b1;
        exp_fetch.delete(); exp_issue.delete();
        m_cnt = 0; eu_cnt = 0;
        mem[0] = 16'h0123; mem[1] = 16'h8000;
        run("after_rst", 0, 3, 0, 0, 1, 2, 1, 0);

`ifdef SV_SQ_WDOG_EN
        // unit never returns ready: abort after 8 WAIT cycles
        mem[16'h10] = 16'h0777; mem[16'h11] = 16'h8000;
        model_run(32'h10, 0);
        eu_lat = 100000; n_pulse = 0; n_done = 0; last_fetch = -1;
        start_prog(32'h10);
        for (int i = 0; i < 200 && n_done == 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("wdog_done",  n_done, 1);
        chk("wdog_delay", done_cyc - pulse_cyc, 9);
        chk("wdog_err",   err_o, 1);
        chk("wdog_busy",  busy_o, 0);
        exp_fetch.delete(); exp_issue.delete();
        eu_lat = 0; eu_cnt = 0; hold = 0;
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
